// File: rtl/dlx_ctrl_fsm_if.sv
// Control/status bundle between the DLX control FSM and its datapath + memory port.
// The master side is the controller; the slave side is the datapath/memory environment.
interface dlx_ctrl_fsm_if #(
  parameter int ST_W = 5
);
  // Decode inputs from the IR environment and register-A zero flag
  logic [5:0]      IR_31_26;
  logic [5:0]      IR_5_0;
  logic            AEQZ;
  // Memory handshake
  logic            ACK;
  logic            MR;
  logic            MW;
  // Datapath enables and selects
  logic            IRCE;
  logic            JLINK;
  logic            PCCE;
  logic [1:0]      PCSEL;
  logic            ACE;
  logic            BCE;
  logic            CCE;
  logic            CSEL;
  logic            BSEL;
  logic [2:0]      ALUF;
  logic            MARCE;
  logic            MDRCE;
  logic            GPR_WE;
  // Status
  logic            HALTED;
  logic            ERR;
  logic [ST_W-1:0] STATE;

  modport master (
    input  IR_31_26, IR_5_0, AEQZ, ACK,
    output IRCE, JLINK, PCCE, PCSEL, ACE, BCE, CCE, CSEL, BSEL, ALUF,
           MARCE, MDRCE, GPR_WE, MR, MW, HALTED, ERR, STATE
  );

  modport slave (
    output IR_31_26, IR_5_0, AEQZ, ACK,
    input  IRCE, JLINK, PCCE, PCSEL, ACE, BCE, CCE, CSEL, BSEL, ALUF,
           MARCE, MDRCE, GPR_WE, MR, MW, HALTED, ERR, STATE
  );
endinterface

// File: rtl/dlx_ctrl_fsm.sv
// Multicycle DLX control FSM: registered Moore outputs, IRCE/MDRCE follow ACK.
// Define WATCHDOG_EN to fault to HALT when a memory access waits TIMEOUT cycles.
module dlx_ctrl_fsm #(
  parameter int TIMEOUT = 255,
  parameter int ST_W    = 5
) (
  input  logic           CLK,
  input  logic           RESET_N,
  dlx_ctrl_fsm_if.master bus
);

  typedef enum logic [ST_W-1:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_ALU,
    S_SHIFT,
    S_ALUI,
    S_ADDR,
    S_LOAD,
    S_COPY,
    S_STORE,
    S_WBR,
    S_WBI,
    S_BRANCH,
    S_BTAKEN,
    S_JR,
    S_SAVEPC,
    S_JALR,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_BEQZ    = 6'h04;
  localparam logic [5:0] OP_BNEZ    = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_JR      = 6'h12;
  localparam logic [5:0] OP_JALR    = 6'h13;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_HALT    = 6'h3F;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;

  // Every Moore-decoded control output, registered as one word
  typedef struct packed {
    logic       jlink;
    logic       pcce;
    logic [1:0] pcsel;
    logic       ace;
    logic       bce;
    logic       cce;
    logic       csel;
    logic       bsel;
    logic [2:0] aluf;
    logic       marce;
    logic       gpr_we;
    logic       mr;
    logic       mw;
    logic       halted;
  } ctrl_t;

  typedef struct packed {
    logic       legal;
    logic       shift;
    logic [2:0] aluf;
  } fn_dec_t;

  state_t  state_q, state_d;
  ctrl_t   ctrl_q, ctrl_d;
  logic    err_q, err_d;
  fn_dec_t fn_dec;
  logic    wd_fire;

  function automatic fn_dec_t decode_fn(input logic [5:0] fn);
    fn_dec_t d;
    d = '{legal: 1'b1, shift: 1'b0, aluf: ALU_ADD};
    unique case (fn)
      6'h20:   d.aluf = ALU_ADD;
      6'h22:   d.aluf = ALU_SUB;
      6'h24:   d.aluf = ALU_AND;
      6'h25:   d.aluf = ALU_OR;
      6'h26:   d.aluf = ALU_XOR;
      6'h04:   begin d.aluf = ALU_SLL; d.shift = 1'b1; end
      6'h06:   begin d.aluf = ALU_SRL; d.shift = 1'b1; end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Outputs are a pure function of the state being entered, so registering
  // them alongside the state gives glitch-free Moore outputs with no extra cycle.
  function automatic ctrl_t moore_out(input state_t s, input logic [2:0] fn_aluf);
    ctrl_t c;
    c = '0;
    unique case (s)
      S_FETCH:  c.mr = 1'b1;
      S_DECODE: begin c.ace = 1'b1; c.bce = 1'b1; c.pcce = 1'b1; c.pcsel = PC_INC; end
      S_ALU,
      S_SHIFT:  begin c.aluf = fn_aluf; c.bsel = 1'b0; c.cce = 1'b1; c.csel = 1'b0; end
      S_ALUI:   begin c.aluf = ALU_ADD; c.bsel = 1'b1; c.cce = 1'b1; end
      S_ADDR:   begin c.aluf = ALU_ADD; c.bsel = 1'b1; c.marce = 1'b1; end
      S_LOAD:   c.mr = 1'b1;
      S_COPY:   begin c.cce = 1'b1; c.csel = 1'b1; end
      S_STORE:  c.mw = 1'b1;
      S_WBR,
      S_WBI:    c.gpr_we = 1'b1;
      S_BTAKEN: begin c.pcce = 1'b1; c.pcsel = PC_REL; end
      S_JR:     begin c.pcce = 1'b1; c.pcsel = PC_REG; end
      S_SAVEPC: begin c.jlink = 1'b1; c.cce = 1'b1; c.csel = 1'b0; c.aluf = ALU_ADD; end
      S_JALR:   begin c.jlink = 1'b1; c.gpr_we = 1'b1; c.pcce = 1'b1; c.pcsel = PC_REG; end
      S_HALT:   c.halted = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign fn_dec = decode_fn(bus.IR_5_0);

`ifdef WATCHDOG_EN
  logic [7:0] wd_q;
  logic       wait_st;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_LOAD) || (state_q == S_STORE);
  assign wd_fire = wait_st && !bus.ACK && (wd_q == 8'(TIMEOUT - 1));

  // Any state change clears the count, which covers every entry into a wait state
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wd_q <= 8'd0;
    end else if (state_d != state_q) begin
      wd_q <= 8'd0;
    end else if (wait_st && !bus.ACK) begin
      wd_q <= wd_q + 8'd1;
    end
  end
`else
  assign wd_fire = (TIMEOUT < 0);
`endif

  always_comb begin
    // NOTE: defaults first, so every path through the case assigns state_d/err_d and no latch is inferred.
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        if (bus.ACK) begin
          state_d = S_DECODE;
        end else if (wd_fire) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_DECODE: begin
        case (bus.IR_31_26)
          OP_SPECIAL: begin
            if (!fn_dec.legal) begin
              state_d = S_HALT;
              err_d   = 1'b1;
            end else begin
              state_d = fn_dec.shift ? S_SHIFT : S_ALU;
            end
          end
          OP_ADDI:         state_d = S_ALUI;
          OP_LW, OP_SW:    state_d = S_ADDR;
          OP_BEQZ, OP_BNEZ: state_d = S_BRANCH;
          OP_JR:           state_d = S_JR;
          OP_JALR:         state_d = S_SAVEPC;
          OP_HALT:         state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        endcase
      end
      S_ALU,
      S_SHIFT:  state_d = S_WBR;
      S_ALUI:   state_d = S_WBI;
      S_ADDR:   state_d = (bus.IR_31_26 == OP_SW) ? S_STORE : S_LOAD;
      S_LOAD: begin
        if (bus.ACK) begin
          state_d = S_COPY;
        end else if (wd_fire) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_COPY:   state_d = S_WBI;
      S_STORE: begin
        if (bus.ACK) begin
          state_d = S_FETCH;
        end else if (wd_fire) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WBR,
      S_WBI:    state_d = S_FETCH;
      // BNEZ inverts the sense of the zero test
      S_BRANCH: state_d = (bus.AEQZ ^ (bus.IR_31_26 == OP_BNEZ)) ? S_BTAKEN : S_FETCH;
      S_BTAKEN,
      S_JR,
      S_JALR:   state_d = S_FETCH;
      S_SAVEPC: state_d = S_JALR;
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
  end

  assign ctrl_d = moore_out(state_d, fn_dec.aluf);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_INIT;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
    end
  end

  // IRCE and MDRCE must capture the word in the ACK cycle itself
  assign bus.IRCE   = (state_q == S_FETCH) && bus.ACK;
  assign bus.MDRCE  = (state_q == S_LOAD) && bus.ACK;
  assign bus.JLINK  = ctrl_q.jlink;
  assign bus.PCCE   = ctrl_q.pcce;
  assign bus.PCSEL  = ctrl_q.pcsel;
  assign bus.ACE    = ctrl_q.ace;
  assign bus.BCE    = ctrl_q.bce;
  assign bus.CCE    = ctrl_q.cce;
  assign bus.CSEL   = ctrl_q.csel;
  assign bus.BSEL   = ctrl_q.bsel;
  assign bus.ALUF   = ctrl_q.aluf;
  assign bus.MARCE  = ctrl_q.marce;
  assign bus.GPR_WE = ctrl_q.gpr_we;
  assign bus.MR     = ctrl_q.mr;
  assign bus.MW     = ctrl_q.mw;
  assign bus.HALTED = ctrl_q.halted;
  assign bus.ERR    = err_q;
  assign bus.STATE  = state_q;

endmodule

// File: tb/tb_dlx_ctrl_fsm.sv
// Scoreboard bench for dlx_ctrl_fsm: the stimulus pushes the expected per-cycle outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_dlx_ctrl_fsm;

  localparam logic [4:0] S_INIT   = 5'd0;
  localparam logic [4:0] S_FETCH  = 5'd1;
  localparam logic [4:0] S_DECODE = 5'd2;
  localparam logic [4:0] S_ALU    = 5'd3;
  localparam logic [4:0] S_SHIFT  = 5'd4;
  localparam logic [4:0] S_ALUI   = 5'd5;
  localparam logic [4:0] S_ADDR   = 5'd6;
  localparam logic [4:0] S_LOAD   = 5'd7;
  localparam logic [4:0] S_COPY   = 5'd8;
  localparam logic [4:0] S_STORE  = 5'd9;
  localparam logic [4:0] S_WBR    = 5'd10;
  localparam logic [4:0] S_WBI    = 5'd11;
  localparam logic [4:0] S_BRANCH = 5'd12;
  localparam logic [4:0] S_BTAKEN = 5'd13;
  localparam logic [4:0] S_JR     = 5'd14;
  localparam logic [4:0] S_SAVEPC = 5'd15;
  localparam logic [4:0] S_JALR   = 5'd16;
  localparam logic [4:0] S_HALT   = 5'd17;

  typedef struct packed {
    logic [4:0] st;
    logic       irce;
    logic       jlink;
    logic       pcce;
    logic [1:0] pcsel;
    logic       ace;
    logic       bce;
    logic       cce;
    logic       csel;
    logic       bsel;
    logic [2:0] aluf;
    logic       marce;
    logic       mdrce;
    logic       gpr_we;
    logic       mr;
    logic       mw;
    logic       halted;
    logic       err;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  e;
  } sb_item_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  sb_item_t sb_q[$];

  logic [5:0] fn_tab   [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h06};
  logic [2:0] aluf_tab [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

  dlx_ctrl_fsm_if #(.ST_W(5)) bus ();

  dlx_ctrl_fsm #(.TIMEOUT(4), .ST_W(5)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic ok);
    n_chk++;
    if (ok === 1'b1) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t", nm, $time);
    end
  endtask

  // Expected outputs for each state, taken from the control table
  function automatic obs_t moore(input logic [4:0] st, input logic [2:0] aluf, input logic err);
    obs_t e;
    e     = '0;
    e.st  = st;
    e.err = err;
    case (st)
      S_FETCH:  e.mr = 1'b1;
      S_DECODE: begin e.ace = 1'b1; e.bce = 1'b1; e.pcce = 1'b1; end
      S_ALU:    begin e.aluf = aluf; e.cce = 1'b1; end
      S_SHIFT:  begin e.aluf = aluf; e.cce = 1'b1; end
      S_ALUI:   begin e.bsel = 1'b1; e.cce = 1'b1; end
      S_ADDR:   begin e.bsel = 1'b1; e.marce = 1'b1; end
      S_LOAD:   e.mr = 1'b1;
      S_COPY:   begin e.cce = 1'b1; e.csel = 1'b1; end
      S_STORE:  e.mw = 1'b1;
      S_WBR:    e.gpr_we = 1'b1;
      S_WBI:    e.gpr_we = 1'b1;
      S_BTAKEN: begin e.pcce = 1'b1; e.pcsel = 2'b01; end
      S_JR:     begin e.pcce = 1'b1; e.pcsel = 2'b10; end
      S_SAVEPC: begin e.jlink = 1'b1; e.cce = 1'b1; end
      S_JALR:   begin e.jlink = 1'b1; e.gpr_we = 1'b1; e.pcce = 1'b1; e.pcsel = 2'b10; end
      S_HALT:   e.halted = 1'b1;
      default:  e = e;
    endcase
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.st     = bus.STATE;
    a.irce   = bus.IRCE;
    a.jlink  = bus.JLINK;
    a.pcce   = bus.PCCE;
    a.pcsel  = bus.PCSEL;
    a.ace    = bus.ACE;
    a.bce    = bus.BCE;
    a.cce    = bus.CCE;
    a.csel   = bus.CSEL;
    a.bsel   = bus.BSEL;
    a.aluf   = bus.ALUF;
    a.marce  = bus.MARCE;
    a.mdrce  = bus.MDRCE;
    a.gpr_we = bus.GPR_WE;
    a.mr     = bus.MR;
    a.mw     = bus.MW;
    a.halted = bus.HALTED;
    a.err    = bus.ERR;
    return a;
  endfunction

  // Monitor: compares mid-cycle, away from the rising edge
  initial begin
    sb_item_t it;
    obs_t     a;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        it = sb_q.pop_front();
        a  = sample();
        check(it.nm, a === it.e);
        if (a !== it.e) begin
          $display("  got state=%0d outs=%h, expected state=%0d outs=%h",
                   a.st, a, it.e.st, it.e);
        end
      end
    end
  end

  // One clock cycle: drive ACK, queue the expected outputs, advance to just after the next edge
  task automatic cyc(input string nm, input logic ack, input logic [4:0] st,
                     input logic [2:0] aluf = 3'b000, input logic err = 1'b0);
    obs_t e;
    bus.ACK = ack;
    e = moore(st, aluf, err);
    if (st == S_FETCH) e.irce  = ack;
    if (st == S_LOAD)  e.mdrce = ack;
    sb_q.push_back('{nm: nm, e: e});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn);
    bus.IR_31_26 = op;
    bus.IR_5_0   = fn;
    cyc("fetch", 1'b1, S_FETCH);
    cyc("decode", 1'b1, S_DECODE);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("reset state", (bus.STATE === S_INIT) && (bus.HALTED === 1'b0) &&
                         (bus.ERR === 1'b0) && (bus.MR === 1'b0) && (bus.MW === 1'b0));
    cyc("reset", 1'b1, S_INIT);
    rst_n = 1'b1;
    cyc("init", 1'b0, S_INIT);
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    rst_n        = 1'b0;
    bus.ACK      = 1'b0;
    bus.AEQZ     = 1'b0;
    bus.IR_31_26 = 6'h00;
    bus.IR_5_0   = 6'h00;
    @(posedge clk);
    #1;
    pulse_reset();

    // All R-type functions: ALU or SHIFT, then register writeback
    for (int i = 0; i < 7; i++) begin
      fetch_decode(6'h00, fn_tab[i]);
      cyc("r-type exec", 1'b1, (i >= 5) ? S_SHIFT : S_ALU, aluf_tab[i]);
      cyc("r-type wbr", 1'b1, S_WBR);
    end

    fetch_decode(6'h08, 6'h00);
    cyc("addi alui", 1'b1, S_ALUI);
    cyc("addi wbi", 1'b1, S_WBI);

    // LW: ACK in ADDR ignored, three wait cycles in LOAD, then ACK
    fetch_decode(6'h23, 6'h00);
    cyc("lw addr", 1'b1, S_ADDR);
    for (int i = 0; i < 3; i++) cyc("lw load wait", 1'b0, S_LOAD);
    cyc("lw load ack", 1'b1, S_LOAD);
    cyc("lw copy", 1'b1, S_COPY);
    cyc("lw wbi", 1'b1, S_WBI);

    fetch_decode(6'h2B, 6'h00);
    cyc("sw addr", 1'b1, S_ADDR);
    cyc("sw store wait", 1'b0, S_STORE);
    cyc("sw store ack", 1'b1, S_STORE);

    bus.AEQZ = 1'b0;
    fetch_decode(6'h05, 6'h00);
    cyc("bnez branch", 1'b1, S_BRANCH);
    cyc("bnez taken", 1'b1, S_BTAKEN);
    bus.AEQZ = 1'b1;
    fetch_decode(6'h05, 6'h00);
    cyc("bnez not taken", 1'b1, S_BRANCH);
    fetch_decode(6'h04, 6'h00);
    cyc("beqz branch", 1'b1, S_BRANCH);
    cyc("beqz taken", 1'b1, S_BTAKEN);
    bus.AEQZ = 1'b0;
    fetch_decode(6'h04, 6'h00);
    cyc("beqz not taken", 1'b1, S_BRANCH);

    fetch_decode(6'h12, 6'h00);
    cyc("jr", 1'b1, S_JR);

    fetch_decode(6'h13, 6'h00);
    cyc("jalr savepc", 1'b1, S_SAVEPC);
    cyc("jalr jalr", 1'b1, S_JALR);

    // Illegal opcode: sticky HALT + ERR despite toggling ACK
    fetch_decode(6'h3E, 6'h00);
    for (int i = 0; i < 20; i++) cyc("illegal op halt", 1'(i), S_HALT, 3'b000, 1'b1);
    pulse_reset();

    fetch_decode(6'h3F, 6'h00);
    for (int i = 0; i < 4; i++) cyc("halt op", 1'(i), S_HALT);
    pulse_reset();

    fetch_decode(6'h00, 6'h21);
    cyc("illegal fn halt", 1'b1, S_HALT, 3'b000, 1'b1);
    pulse_reset();

    // ACK held low in FETCH: watchdog fires after TIMEOUT cycles, else waits
    for (int i = 0; i < 6; i++) begin
`ifdef WATCHDOG_EN
      if (i < 4) cyc("fetch no ack", 1'b0, S_FETCH);
      else       cyc("watchdog halt", 1'b0, S_HALT, 3'b000, 1'b1);
`else
      cyc("fetch no ack", 1'b0, S_FETCH);
`endif
    end
`ifdef WATCHDOG_EN
    check("expired wait faults", (bus.STATE === S_HALT) && (bus.ERR === 1'b1) &&
                                 (bus.HALTED === 1'b1) && (bus.MR === 1'b0));
`else
    check("expired wait keeps waiting", (bus.STATE === S_FETCH) && (bus.ERR === 1'b0) &&
                                        (bus.MR === 1'b1));
`endif
    pulse_reset();

    // Reset in the middle of a pending fetch drops MR immediately
    cyc("fetch pending", 1'b0, S_FETCH);
    pulse_reset();
    fetch_decode(6'h08, 6'h00);
    cyc("post-abort alui", 1'b1, S_ALUI);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dlx_ctrl_fsm.md
Name: dlx_ctrl_fsm

Overview:
- Multicycle control state machine for the DLX core. It sequences the instruction register environment, GPR file, ALU, PC and the memory interface.
- Issues IRCE to latch the fetched word and JLINK to force RD=31 on JALR writeback.
- Decodes the opcode and function fields presented by the IR environment, which already returns function 0 for non-R-type opcodes.
- Drives the memory handshake (MR/MW with ACK).

Parameters:
TIMEOUT, 255, max cycles MR/MW may wait for ACK before fault (WATCHDOG_EN only)
ST_W, 5, width of state register / STATE debug port

Ports:
CLK input 1 system clock, rising edge
RESET_N input 1 asynchronous active-low reset
IR_31_26 input 6 opcode from IR environment
IR_5_0 input 6 R-type function (0 for non-R-type)
AEQZ input 1 register A equals zero
ACK input 1 memory access complete, sampled on CLK rising edge
IRCE output 1 IR clock enable
JLINK output 1 force destination to R31
PCCE output 1 PC clock enable
PCSEL output 2 00 PC+4, 01 PC+4+imm, 10 A
ACE output 1 A latch enable
BCE output 1 B latch enable
CCE output 1 C latch enable
CSEL output 1 C source: 0 ALU, 1 MDR
BSEL output 1 ALU B operand: 0 B, 1 imm
ALUF output 3 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL
MARCE output 1 MAR enable
MDRCE output 1 MDR enable
GPR_WE output 1 register file write
MR output 1 memory read request
MW output 1 memory write request
HALTED output 1 sticky halt indicator
ERR output 1 sticky fault (illegal opcode or timeout)
STATE output ST_W current state, debug

Behaviour:
- All outputs are Moore decodes of the registered state, with two exceptions: IRCE=ACK in FETCH and MDRCE=ACK in LOAD.
- RESET_N low: state=INIT and all outputs 0, including HALTED and ERR. Reset is asynchronous and aborts any transaction; MR/MW drop immediately.
- INIT: no outputs asserted. Goes to FETCH next cycle.
- FETCH: MR=1. Stays while ACK=0; on ACK=1, IRCE=1 and goes to DECODE.
- DECODE: ACE=BCE=1, PCCE=1, PCSEL=00. Next state by opcode:
  - 0x00 SPECIAL: function 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR go to ALU; 0x04 SLL, 0x06 SRL go to SHIFT; any other function goes to HALT with ERR.
  - 0x08 ADDI goes to ALUI.
  - 0x23 LW and 0x2B SW go to ADDR.
  - 0x04 BEQZ and 0x05 BNEZ go to BRANCH.
  - 0x12 JR goes to JR.
  - 0x13 JALR goes to SAVEPC.
  - 0x3F goes to HALT without ERR.
  - Any other opcode goes to HALT with ERR=1.
- ALU and SHIFT: ALUF from function, BSEL=0, CCE=1, CSEL=0. Go to WBR.
- ALUI: ALUF=ADD, BSEL=1, CCE=1. Go to WBI.
- ADDR: ALUF=ADD, BSEL=1, MARCE=1. Go to LOAD for LW, STORE for SW.
- LOAD: MR=1. Waits for ACK; MDRCE=ACK. Goes to COPY.
- COPY: CCE=1, CSEL=1. Go to WBI.
- STORE: MW=1. Waits for ACK. Goes to FETCH.
- WBR and WBI: GPR_WE=1. Go to FETCH.
- BRANCH: taken when AEQZ XOR (opcode==0x05). Taken goes to BTAKEN; not taken goes to FETCH.
- BTAKEN: PCCE=1, PCSEL=01. Go to FETCH.
- JR: PCCE=1, PCSEL=10. Go to FETCH.
- SAVEPC: JLINK=1, CCE=1, CSEL=0, ALUF=ADD. PC is passed through to C. Go to JALR.
- JALR: JLINK=1, GPR_WE=1, PCCE=1, PCSEL=10. Go to FETCH.
- HALT: HALTED=1. Absorbing state; only RESET_N exits it. ERR holds its value.
- ACK asserted outside FETCH, LOAD or STORE is ignored.
- MR and MW are never asserted in the same cycle.
- An ACK coinciding with the first request cycle completes the access in 1 cycle.

Optional Feature:
WATCHDOG_EN
- Defined: an 8-bit counter clears on entry to FETCH, LOAD or STORE and increments each cycle ACK=0. When it reaches TIMEOUT with ACK still low, the FSM goes to HALT with ERR=1 and MR/MW drop next cycle. Counter resets to 0.
- Undefined: no counter; the FSM waits for ACK indefinitely.

Test Plan:
- Reset, then ACK=1 every cycle, opcode 0x00 / function 0x20 (ADD): STATE sequence INIT, FETCH, DECODE, ALU, WBR, FETCH. Check IRCE=1 in FETCH, ALUF=000, GPR_WE=1 in exactly one cycle.
- LW (0x23) with ACK delayed 3 cycles in LOAD: MR held high 4 cycles, MDRCE=1 only in the ACK cycle, then COPY (CSEL=1) then WBI.
- BNEZ (0x05) with AEQZ=0: BTAKEN, PCSEL=01, PCCE=1. Repeat with AEQZ=1: BRANCH goes straight to FETCH with no PCCE in that cycle.
- JALR (0x13): JLINK=1 in both SAVEPC and JALR; GPR_WE=1 and PCSEL=10 in JALR.
- Opcode 0x3E: HALT with ERR=1 and HALTED=1, held for 20 cycles despite ACK toggling. RESET_N pulse low clears both to 0.
- WATCHDOG_EN with TIMEOUT=4, ACK=0 in FETCH: MR high for 4 cycles, then HALT with ERR=1 and MR=0.
